// File: rtl/ddr3_init_sequencer_pkg.sv
// Shared types for the DDR3 power-up sequencer: PHY command encoding, FSM states
// and the JEDEC mode-register programming order.
package ddr3_init_sequencer_pkg;

  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_RESET    = 3'd1,
    CMD_POWER_UP = 3'd2,
    CMD_MRS      = 3'd3,
    CMD_ZQCAL    = 3'd4
  } command_t;

  typedef enum logic [3:0] {
    INIT_RESET    = 4'd0,
    INIT_CKE_LOW  = 4'd1,
    INIT_XPR      = 4'd2,
    INIT_MRS      = 4'd3,
    INIT_WAIT_MRD = 4'd4,
    INIT_WAIT_MOD = 4'd5,
    INIT_ZQCL     = 4'd6,
    INIT_WAIT_ZQ  = 4'd7,
    INIT_DONE     = 4'd8
  } init_state_t;

  // Entry i is the MR programmed on the i-th MRS: 2, 3, 1, 0.
  localparam logic [3:0][1:0] MR_ORDER = {2'd0, 2'd1, 2'd3, 2'd2};

  function automatic command_t state_command(input init_state_t s);
    command_t c;
    case (s)
      INIT_RESET:   c = CMD_RESET;
      INIT_CKE_LOW: c = CMD_POWER_UP;
      INIT_MRS:     c = CMD_MRS;
      INIT_ZQCL:    c = CMD_ZQCAL;
      default:      c = CMD_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ddr3_init_sequencer_init_timer.sv
// Interval timer for the init sequencer: counts up from 0 and flags the cycle on
// which the count equals the programmable terminal value.
module ddr3_init_sequencer_init_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] terminal_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: restart on clear, otherwise advance.
  always_comb begin
    if (clear_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == terminal_i);

endmodule

// File: rtl/ddr3_init_sequencer.sv
// DDR3 power-up/initialization sequencer driving the PHY command bus until done.
// Optional feature macro INIT_REINIT_EN adds i_reinit_req to replay the sequence from INIT_DONE.
module ddr3_init_sequencer
  import ddr3_init_sequencer_pkg::*;
#(
  parameter int T_RESET_CYC  = 200,
  parameter int T_CKE_CYC    = 500,
  parameter int T_XPR_CYC    = 128,
  parameter int T_MRD_CYC    = 4,
  parameter int T_MOD_CYC    = 12,
  parameter int T_ZQINIT_CYC = 512,
  parameter int CNT_W        = 16
) (
  input  logic        clk1,
  input  logic        rst_n,
`ifdef INIT_REINIT_EN
  input  logic        i_reinit_req,
`endif
  output command_t    o_command,
  output logic [1:0]  o_mode_register_num,
  output logic        o_init_done,
  output init_state_t o_init_state
);

  localparam int MAX_CYC = (32'sd1 <<< CNT_W) - 32'sd1;

  if (T_RESET_CYC < 32'sd1 || T_RESET_CYC > MAX_CYC ||
      T_CKE_CYC < 32'sd1 || T_CKE_CYC > MAX_CYC ||
      T_XPR_CYC < 32'sd1 || T_XPR_CYC > MAX_CYC ||
      T_MRD_CYC < 32'sd2 || T_MRD_CYC > MAX_CYC ||
      T_MOD_CYC < 32'sd2 || T_MOD_CYC > MAX_CYC ||
      T_ZQINIT_CYC < 32'sd2 || T_ZQINIT_CYC > MAX_CYC) begin : g_bad_timing
    $error("ddr3_init_sequencer: timing parameter below minimum or exceeds CNT_W range");
  end

  // Wait states exclude the MRS/ZQCL cycle that precedes them, hence the -2.
  localparam logic [CNT_W-1:0] TERM_RESET = CNT_W'(T_RESET_CYC - 1);
  localparam logic [CNT_W-1:0] TERM_CKE   = CNT_W'(T_CKE_CYC - 1);
  localparam logic [CNT_W-1:0] TERM_XPR   = CNT_W'(T_XPR_CYC - 1);
  localparam logic [CNT_W-1:0] TERM_MRD   = CNT_W'(T_MRD_CYC - 2);
  localparam logic [CNT_W-1:0] TERM_MOD   = CNT_W'(T_MOD_CYC - 2);
  localparam logic [CNT_W-1:0] TERM_ZQ    = CNT_W'(T_ZQINIT_CYC - 2);

  init_state_t      state_q, state_d;
  logic [1:0]       mr_idx_q, mr_idx_d;
  command_t         command_q;
  logic [1:0]       mr_num_q;
  logic             done_q;
  logic [CNT_W-1:0] terminal_s;
  logic             expire_s;
  logic             timer_clear_s;

  // Every exit happens on expiry, so expiry doubles as the timer clear.
  assign timer_clear_s = expire_s || (state_q == INIT_DONE);

  ddr3_init_sequencer_init_timer #(.CNT_W(CNT_W)) u_timer (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .clear_i    (timer_clear_s),
    .terminal_i (terminal_s),
    .expire_o   (expire_s)
  );

  // Terminal count for the interval of the current state.
  always_comb begin
    case (state_q)
      INIT_RESET:    terminal_s = TERM_RESET;
      INIT_CKE_LOW:  terminal_s = TERM_CKE;
      INIT_XPR:      terminal_s = TERM_XPR;
      INIT_WAIT_MRD: terminal_s = TERM_MRD;
      INIT_WAIT_MOD: terminal_s = TERM_MOD;
      INIT_WAIT_ZQ:  terminal_s = TERM_ZQ;
      default:       terminal_s = '0;
    endcase
  end

  // Next-state and MR index selection.
  always_comb begin
    state_d  = state_q;
    mr_idx_d = mr_idx_q;
    case (state_q)
      INIT_RESET:    state_d = expire_s ? INIT_CKE_LOW : INIT_RESET;
      INIT_CKE_LOW:  state_d = expire_s ? INIT_XPR : INIT_CKE_LOW;
      INIT_XPR:      state_d = expire_s ? INIT_MRS : INIT_XPR;
      INIT_MRS:      state_d = (mr_idx_q == 2'd3) ? INIT_WAIT_MOD : INIT_WAIT_MRD;
      INIT_WAIT_MRD: begin
        if (expire_s) begin
          state_d  = INIT_MRS;
          mr_idx_d = mr_idx_q + 2'd1;
        end else begin
          state_d  = INIT_WAIT_MRD;
        end
      end
      INIT_WAIT_MOD: state_d = expire_s ? INIT_ZQCL : INIT_WAIT_MOD;
      INIT_ZQCL:     state_d = INIT_WAIT_ZQ;
      INIT_WAIT_ZQ:  state_d = expire_s ? INIT_DONE : INIT_WAIT_ZQ;
      INIT_DONE: begin
`ifdef INIT_REINIT_EN
        if (i_reinit_req) begin
          state_d  = INIT_RESET;
          mr_idx_d = 2'd0;
        end else begin
          state_d  = INIT_DONE;
        end
`else
        state_d = INIT_DONE;
`endif
      end
      default:       state_d = INIT_RESET;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT_RESET;
      mr_idx_q  <= 2'd0;
      command_q <= CMD_RESET;
      mr_num_q  <= 2'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mr_idx_q  <= mr_idx_d;
      command_q <= state_command(state_d);
      mr_num_q  <= (state_d == INIT_MRS) ? MR_ORDER[mr_idx_d] : 2'd0;
      done_q    <= (state_d == INIT_DONE);
    end
  end

  assign o_command           = command_q;
  assign o_mode_register_num = mr_num_q;
  assign o_init_done         = done_q;
  assign o_init_state        = state_q;

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// Self-checking bench for ddr3_init_sequencer: default and minimum-timing instances
// checked every cycle against a schedule model, plus literal checkpoints.
module tb_ddr3_init_sequencer;
  import ddr3_init_sequencer_pkg::*;

`ifdef INIT_REINIT_EN
  localparam bit REINIT = 1'b1;
`else
  localparam bit REINIT = 1'b0;
`endif
  localparam int L_A = 1364;
  localparam int L_B = 13;

  logic clk1 = 1'b0;
  logic rst_n = 1'b0;
  logic reinit_req = 1'b0;

  command_t    cmd_a, cmd_b;
  logic [1:0]  mr_a, mr_b;
  logic        done_a, done_b;
  init_state_t st_a, st_b;

  int checks = 0;
  int fails = 0;
  int cnt_a = 0;
  int cnt_b = 0;

  int       n_mrs = 0;
  int       n_zq = 0;
  command_t prev_cmd = CMD_RESET;
  logic     prev_done = 1'b0;

  always #5 clk1 = ~clk1;

  ddr3_init_sequencer u_a (
    .clk1                (clk1),
    .rst_n               (rst_n),
`ifdef INIT_REINIT_EN
    .i_reinit_req        (reinit_req),
`endif
    .o_command           (cmd_a),
    .o_mode_register_num (mr_a),
    .o_init_done         (done_a),
    .o_init_state        (st_a)
  );

  ddr3_init_sequencer #(
    .T_RESET_CYC(1), .T_CKE_CYC(1), .T_XPR_CYC(1),
    .T_MRD_CYC(2), .T_MOD_CYC(2), .T_ZQINIT_CYC(2)
  ) u_b (
    .clk1                (clk1),
    .rst_n               (rst_n),
`ifdef INIT_REINIT_EN
    .i_reinit_req        (reinit_req),
`endif
    .o_command           (cmd_b),
    .o_mode_register_num (mr_b),
    .o_init_done         (done_b),
    .o_init_state        (st_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs at cycle c (c = posedges since reset release or reinit).
  function automatic void model(input int c, input int tr, input int tc, input int tx,
                                input int tm, input int tmod, input int tz,
                                output command_t cmd, output logic [1:0] mr, output logic done);
    int order [4];
    int first_mrs;
    int zq;
    order = '{2, 3, 1, 0};
    first_mrs = tr + tc + tx;
    zq = first_mrs + 3 * tm + tmod;
    cmd = CMD_NOP;
    mr = 2'd0;
    done = 1'b0;
    if (c < tr) cmd = CMD_RESET;
    else if (c < tr + tc) cmd = CMD_POWER_UP;
    else if (c >= first_mrs && c <= first_mrs + 3 * tm && ((c - first_mrs) % tm) == 0) begin
      cmd = CMD_MRS;
      mr = 2'(order[(c - first_mrs) / tm]);
    end
    else if (c == zq) cmd = CMD_ZQCAL;
    else if (c >= zq + tz) done = 1'b1;
  endfunction

  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= 0;
      cnt_b <= 0;
    end else begin
      cnt_a <= (REINIT && reinit_req && cnt_a >= L_A) ? 0 : cnt_a + 1;
      cnt_b <= (REINIT && reinit_req && cnt_b >= L_B) ? 0 : cnt_b + 1;
    end
  end

  always @(negedge clk1) begin
    command_t ec;
    logic [1:0] em;
    logic ed;
    if (!rst_n) begin ec = CMD_RESET; em = 2'd0; ed = 1'b0; end
    else model(cnt_a, 200, 500, 128, 4, 12, 512, ec, em, ed);
    check("a_cmd", cmd_a, ec);
    check("a_mr", mr_a, em);
    check("a_done", done_a, ed);
    if (!rst_n) begin ec = CMD_RESET; em = 2'd0; ed = 1'b0; end
    else model(cnt_b, 1, 1, 1, 2, 2, 2, ec, em, ed);
    check("b_cmd", cmd_b, ec);
    check("b_mr", mr_b, em);
    check("b_done", done_b, ed);
  end

  always @(negedge clk1) begin
    if (!rst_n) begin
      n_mrs = 0;
      n_zq = 0;
      prev_cmd = CMD_RESET;
      prev_done = 1'b0;
    end else begin
      if (cmd_a == CMD_MRS || cmd_a == CMD_ZQCAL) begin
        checks++;
        if (prev_cmd == cmd_a) begin
          fails++;
          $display("FAIL a_no_repeat: command %0d repeated back-to-back", cmd_a);
        end
      end
      if (cmd_a == CMD_MRS) n_mrs++;
      if (cmd_a == CMD_ZQCAL) n_zq++;
      if (done_a && !prev_done) begin
        check("a_mrs_per_pass", n_mrs, 4);
        check("a_zq_per_pass", n_zq, 1);
        n_mrs = 0;
        n_zq = 0;
      end
      prev_cmd = cmd_a;
      prev_done = done_a;
    end
  end

  task automatic wait_cycle(input int c);
    int guard;
    guard = 0;
    @(negedge clk1);
    while (cnt_a != c && guard < 5000) begin
      @(negedge clk1);
      guard++;
    end
    check("wait_cycle", cnt_a, c);
  endtask

  initial begin
    repeat (3) @(negedge clk1);
    #1;
    check("rst_cmd", cmd_a, CMD_RESET);
    check("rst_mr", mr_a, 2'd0);
    check("rst_done", done_a, 1'b0);
    check("rst_state", st_a, INIT_RESET);
    check("rst_state_b", st_b, INIT_RESET);
    #1 rst_n = 1'b1;

    wait_cycle(12);  check("b_done_12", done_b, 1'b0);
    wait_cycle(13);  check("b_done_13", done_b, 1'b1);
    wait_cycle(199); check("a_cmd_199", cmd_a, CMD_RESET);
    wait_cycle(200); check("a_cmd_200", cmd_a, CMD_POWER_UP);
    wait_cycle(700); check("a_cmd_700", cmd_a, CMD_NOP);
    wait_cycle(828); check("a_cmd_828", cmd_a, CMD_MRS); check("a_mr_828", mr_a, 2'd2);
    wait_cycle(832); check("a_mr_832", mr_a, 2'd3);

    wait_cycle(834);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cmd", cmd_a, CMD_RESET);
    check("midrst_done", done_a, 1'b0);
    check("midrst_done_b", done_b, 1'b0);
    check("midrst_state", st_a, INIT_RESET);
    @(negedge clk1);
    @(negedge clk1);
    #2 rst_n = 1'b1;

    wait_cycle(828);  check("r_cmd_828", cmd_a, CMD_MRS); check("r_mr_828", mr_a, 2'd2);
    wait_cycle(840);  check("r_mr_840", mr_a, 2'd0);
    wait_cycle(852);  check("r_cmd_852", cmd_a, CMD_ZQCAL);
    wait_cycle(1363); check("r_done_1363", done_a, 1'b0);
    wait_cycle(1364); check("r_done_1364", done_a, 1'b1); check("r_state_1364", st_a, INIT_DONE);
    wait_cycle(1400); check("r_cmd_1400", cmd_a, CMD_NOP);

`ifdef INIT_REINIT_EN
    reinit_req = 1'b1;
    @(negedge clk1);
    reinit_req = 1'b0;
    check("reinit_done_fall", done_a, 1'b0);
    check("reinit_cmd", cmd_a, CMD_RESET);
    wait_cycle(750);
    reinit_req = 1'b1;
    @(negedge clk1);
    reinit_req = 1'b0;
    check("xpr_ignore_cmd", cmd_a, CMD_NOP);
    wait_cycle(1363); check("re_done_1363", done_a, 1'b0);
    wait_cycle(1364); check("re_done_1364", done_a, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
